// File: rtl/row_col_pkg.sv
// Shared types, defaults and element-select helper for the row_col dot-product engine.
package row_col_pkg;

    localparam int WIDTH   = 32;
    localparam int N       = 3;
    // Upper bounds for the generic element selector; width*n must fit in MAX_VEC.
    localparam int MAX_W   = 64;
    localparam int MAX_VEC = 4096;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic [MAX_W-1:0] elem_sel(input logic [MAX_VEC-1:0] vec,
                                                  input int w,
                                                  input int i);
        return MAX_W'(vec >> (i * w));
    endfunction

endpackage

// File: rtl/row_col_mac.sv
// Combinational multiply-accumulate: acc + low width bits of x*y, wrapping modulo 2^width.
module row_col_mac
    import row_col_pkg::*;
#(
    parameter int width = WIDTH
) (
    input  logic [width-1:0] acc,
    input  logic [width-1:0] x,
    input  logic [width-1:0] y,
    output logic [width-1:0] sum
);

    logic [2*width-1:0] prod;

    function automatic logic [width-1:0] trunc_w(input logic [2*width-1:0] p);
        return p[width-1:0];
    endfunction

    assign prod = {{width{1'b0}}, x} * {{width{1'b0}}, y};
    assign sum  = acc + trunc_w(prod);

endmodule

// File: rtl/row_col.sv
// Sequential dot product of row a and column b, one MAC per clock; done pulses with a new c.
module row_col
    import row_col_pkg::*;
#(
    parameter int width = WIDTH,
    parameter int n     = N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [width*n-1:0] a,
    input  logic [width*n-1:0] b,
    output logic [width-1:0]   c,
    output logic               done
);

    localparam int IW = (n > 1) ? $clog2(n) : 1;
    localparam logic [IW-1:0] LAST = IW'(n - 1);

    state_t             state, state_n;
    logic               start_q;
    logic [width*n-1:0] a_q, b_q;
    logic [width-1:0]   acc;
    logic [IW-1:0]      idx;
    logic [width-1:0]   x_cur, y_cur, mac_sum;
    logic               rise, last;

    assign rise  = start & ~start_q;
    assign last  = (idx == LAST);
    assign x_cur = width'(elem_sel(MAX_VEC'(a_q), width, int'(idx)));
    assign y_cur = width'(elem_sel(MAX_VEC'(b_q), width, int'(idx)));

    row_col_mac #(.width(width)) u_mac (
        .acc (acc),
        .x   (x_cur),
        .y   (y_cur),
        .sum (mac_sum)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (rise) state_n = BUSY;
            BUSY:    if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand registers are loaded only on a trigger, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            start_q <= 1'b0;
            acc     <= '0;
            idx     <= '0;
            c       <= '0;
            done    <= 1'b0;
        end else begin
            start_q <= start;
            state   <= state_n;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        a_q <= a;
                        b_q <= b;
                        acc <= '0;
                        idx <= '0;
                    end
                end
                BUSY: begin
                    acc <= mac_sum;
                    idx <= idx + IW'(1);
                    if (last) begin
                        c    <= mac_sum;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_row_col.sv
// Scoreboard bench for row_col: stimulus queues expected results, a monitor checks each done.
module tb_row_col;

    localparam int W  = 32;
    localparam int NE = 3;

    typedef struct packed {
        logic [W-1:0]  c;
        logic [31:0]   cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [W*NE-1:0] av, bv;
    logic [W-1:0]    c;
    logic            done;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] cyc = 0;

    row_col #(.width(W), .n(NE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (av),
        .b     (bv),
        .c     (c),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W*NE-1:0] pack3(input logic [W-1:0] e0, e1, e2);
        return {e2, e1, e0};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done must match the oldest queued expectation in value and cycle.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_c", c, e.c);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL done_timeout: got %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Start is raised just after an edge; the trigger edge is the next one.
    task automatic run(input logic [W*NE-1:0] ta, tb, input logic [W-1:0] expc, input int hold);
        @(posedge clk); #1;
        av    = ta;
        bv    = tb;
        start = 1'b1;
        sb.push_back('{c: expc, cyc: cyc + NE + 1});
        repeat (hold) @(posedge clk);
        #1 start = 1'b0;
        drain();
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        av    = '0;
        bv    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_c", c, '0);
        check("reset_done", {31'b0, done}, '0);

        // Basic: start rises together with reset release
        av    = pack3(10, 9, 8);
        bv    = pack3(1, 2, 3);
        rst   = 1'b1;
        start = 1'b1;
        sb.push_back('{c: 52, cyc: cyc + NE + 1});
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        drain();

        // Zero and identity
        run(pack3(0, 0, 0), pack3(1, 2, 3), 0, 1);
        run(pack3(5, 6, 7), pack3(1, 1, 1), 18, 1);

        // Wrap-around of product and accumulator
        run(pack3(32'hFFFFFFFF, 0, 0), pack3(32'hFFFFFFFF, 0, 0), 1, 1);
        run(pack3(32'h80000000, 32'h80000000, 0), pack3(2, 2, 0), 0, 1);

        // Start held long; operands change mid-computation
        @(posedge clk); #1;
        av    = pack3(10, 9, 8);
        bv    = pack3(1, 2, 3);
        start = 1'b1;
        sb.push_back('{c: 52, cyc: cyc + NE + 1});
        repeat (2) @(posedge clk);
        #1;
        av = pack3(100, 200, 300);
        bv = pack3(7, 7, 7);
        repeat (12) @(posedge clk);
        #1 start = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        #1 check("held_c_stable", c, 52);

        // Reset on the edge after the trigger discards the computation
        @(posedge clk); #1;
        av    = pack3(4, 4, 4);
        bv    = pack3(4, 4, 4);
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midreset_c", c, '0);
        check("midreset_done", {31'b0, done}, '0);
        run(pack3(1, 2, 3), pack3(4, 5, 6), 32, 1);

        // Back-to-back, with a second start edge during BUSY that must be ignored
        run(pack3(2, 3, 4), pack3(5, 6, 7), 56, 1);
        @(posedge clk); #1;
        av    = pack3(11, 12, 13);
        bv    = pack3(1, 1, 2);
        start = 1'b1;
        sb.push_back('{c: 49, cyc: cyc + NE + 1});
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        drain();
        run(pack3(32'hFFFFFFFF, 1, 2), pack3(1, 1, 3), 6, 1);
        repeat (8) @(posedge clk);
        #1 check("final_c", c, 6);

        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL leftover: got %0d queued results, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier end");
        $fatal(1, "watchdog");
    end

endmodule
